msi_stim_sequencer: RTL
=======================

Name: msi_stim_sequencer

Overview:
- Parametrised, programmable stimulus sequencer for the MSI directory-protocol test bench.
- Replaces the fixed, initial-block, free-running request list with a run-time-loaded program memory and a valid/ready request handshake.
- Adds a programmable run length, a done flag and abort.
- Drives (processor, op, address, data) requests into the L1/directory model under test, one request per accepted handshake.

Parameters:
- ADDR_W, 4, request address code width
- DATA_W, 4, request data code width
- PROC_W, 2, processor id width (P0,0 = 0, P0,1 = 1, ...)
- DEPTH, 16, program entries (>= 2)
- IDX_W, $clog2(DEPTH), entry index width

Ports:
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- ProgWe  in  1  program write strobe
- ProgIdx  in  IDX_W  program entry index
- ProgProc  in  PROC_W  entry processor
- ProgOp  in  2  entry op: 00 Read, 01 Write, 10/11 reserved (issued as-is)
- ProgAddr  in  ADDR_W  entry address code
- ProgData  in  DATA_W  entry data code
- Length  in  IDX_W+1  number of entries to issue
- Start  in  1  begin run (level sampled)
- Abort  in  1  stop run
- Loop  in  1  wrap at end (LOOP_EN builds only)
- ReqValid  out  1  request valid
- ReqReady  in  1  consumer accepts request
- Processor  out  PROC_W  request processor
- WriteOrRead  out  2  request op
- AddressTest  out  ADDR_W  request address
- DataTest  out  DATA_W  request data
- Busy  out  1  state is RUN
- Done  out  1  run completed
- IssuedCount  out  IDX_W+1  handshakes completed in current run

Behaviour:
- Reset (async, Reset_n=0):
  - state IDLE; all outputs 0.
  - Program memory contents are undefined; memory is not reset.
- States: IDLE, RUN, DONE.
- Program writes:
  - Accepted on a rising edge with ProgWe=1 in IDLE or DONE.
  - Ignored in RUN.
  - ProgIdx >= DEPTH is ignored.
- IDLE/DONE to RUN:
  - Condition: Start=1, ProgWe=0, Length != 0.
  - Start is ignored when ProgWe=1 in the same cycle, or when Length=0.
  - Effective length is min(Length, DEPTH), latched at Start.
  - On the same edge: idx=0, entry 0 loaded into output regs, ReqValid=1, Done=0, IssuedCount=0.
  - Latency is 1 cycle from Start sampled to the first valid request.
- RUN:
  - Outputs are registered and held stable while ReqValid && !ReqReady.
  - Handshake = ReqValid && ReqReady at a rising edge. On each handshake IssuedCount increments.
  - If idx < len-1: idx+1, next entry loaded on the same edge. This gives back-to-back throughput of 1 request/cycle with ReqReady held at 1.
  - If idx == len-1: go to DONE, ReqValid=0, Done=1.
- Abort:
  - Abort=1 in RUN returns to IDLE on the next edge with ReqValid=0 and Done=0. A pending request is dropped.
  - Abort has priority over a handshake in the same cycle: IssuedCount is not incremented.
  - In IDLE/DONE, Abort clears Done and goes to IDLE.
- DONE:
  - Done held at 1; IssuedCount and the last request fields are held (fields only; ReqValid=0).
  - Start restarts the run as from IDLE.
- Busy = (state == RUN).
- A length of 1 issues exactly one request, then goes to DONE.
- Entries with reserved op codes are issued unchanged.

Optional Feature:
- Macro: MSI_STIM_LOOP_EN.
- Defined:
  - On the last-entry handshake with Loop=1: idx wraps to 0, entry 0 is loaded, state stays RUN, Done pulses 1 for one cycle.
  - IssuedCount saturates at all-ones.
  - Loop=0 behaves as the non-looping build.
- Undefined: the Loop input is ignored and the run always ends in DONE.

Decomposition:
- Package msi_test_pkg holds:
  - op codes: OP_READ=2'b00, OP_WRITE=2'b01;
  - processor ids P00=0, P01=1;
  - address codes A100=1 .. A138=8;
  - data codes D08=1 .. D90=9;
  - state enum encoding.
- Sub-module msi_stim_mem: DEPTH x (PROC_W+2+ADDR_W+DATA_W) register array, synchronous write, asynchronous read.
- The FSM, index and counter logic live in msi_stim_sequencer.

Test Plan:
- Back-to-back run:
  - Program 8 entries, e.g. entry 2 = P00, Write, A128, D78; entry 5 = P01, Write, A120, D80. Length=8, ReqReady=1.
  - ReqValid rises 1 cycle after Start.
  - 8 consecutive requests in programmed order, Done=1 at cycle 9, IssuedCount=8.
- Backpressure: ReqReady toggles 1,0,0,1,... Each request stays stable while stalled; exactly 8 handshakes; no entry is skipped or duplicated.
- Length edge cases:
  - Length=0: Start ignored, Busy stays 0.
  - Length=1: one request, then Done.
  - Length=DEPTH+5: exactly DEPTH requests are issued.
- Abort:
  - Abort at the 3rd request with ReqReady=1 in the same cycle: IssuedCount=2, state IDLE, ReqValid=0.
  - Async Reset_n low mid-run: all outputs 0 immediately.
- Program and Start interaction:
  - ProgWe during RUN does not alter the sequence.
  - ProgWe with Start in the same cycle: no run starts.
  - Restart from DONE reissues the updated program.
- LOOP_EN build, Length=3, Loop=1: sequence 0,1,2,0,1,2; Done pulses for one cycle at each wrap; IssuedCount=6 after 6 handshakes.

Source files
------------

// File: rtl/msi_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : msi_test_pkg
//  Purpose  : Shared codes for the MSI directory-protocol stimulus sequencer:
//             op codes, processor ids, address/data codes and the FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package msi_test_pkg;

    // Request op codes (10/11 are reserved and issued unchanged)
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;

    // Processor ids
    localparam logic [1:0] P00 = 2'd0;
    localparam logic [1:0] P01 = 2'd1;

    // Address codes
    localparam logic [3:0] A100 = 4'd1;
    localparam logic [3:0] A104 = 4'd2;
    localparam logic [3:0] A108 = 4'd3;
    localparam logic [3:0] A112 = 4'd4;
    localparam logic [3:0] A120 = 4'd5;
    localparam logic [3:0] A124 = 4'd6;
    localparam logic [3:0] A128 = 4'd7;
    localparam logic [3:0] A138 = 4'd8;

    // Data codes
    localparam logic [3:0] D08 = 4'd1;
    localparam logic [3:0] D10 = 4'd2;
    localparam logic [3:0] D20 = 4'd3;
    localparam logic [3:0] D30 = 4'd4;
    localparam logic [3:0] D40 = 4'd5;
    localparam logic [3:0] D50 = 4'd6;
    localparam logic [3:0] D78 = 4'd7;
    localparam logic [3:0] D80 = 4'd8;
    localparam logic [3:0] D90 = 4'd9;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/msi_stim_mem.sv
`default_nettype none
// ============================================================================
//  Module   : msi_stim_mem
//  Purpose  : Program memory for the stimulus sequencer. DEPTH x WIDTH
//             register array, synchronous write, asynchronous read.
//             Contents are not reset.
//  Revision : 1.0  initial release
// ============================================================================
module msi_stim_mem #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Entry write; the caller has already qualified the strobe and index
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/msi_stim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : msi_stim_sequencer
//  Purpose  : Programmable MSI stimulus sequencer. Issues (processor, op,
//             address, data) requests from a run-time loaded program over a
//             valid/ready handshake, with run length, done flag and abort.
//  Options  : MSI_STIM_LOOP_EN - when defined, Loop=1 wraps the run back to
//             entry 0 after the last entry instead of finishing.
//  Revision : 1.0  initial release
// ============================================================================
module msi_stim_sequencer
    import msi_test_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int PROC_W = 2,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              ProgWe,
    input  logic [IDX_W-1:0]  ProgIdx,
    input  logic [PROC_W-1:0] ProgProc,
    input  logic [1:0]        ProgOp,
    input  logic [ADDR_W-1:0] ProgAddr,
    input  logic [DATA_W-1:0] ProgData,
    input  logic [IDX_W:0]    Length,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Loop,
    output logic              ReqValid,
    input  logic              ReqReady,
    output logic [PROC_W-1:0] Processor,
    output logic [1:0]        WriteOrRead,
    output logic [ADDR_W-1:0] AddressTest,
    output logic [DATA_W-1:0] DataTest,
    output logic              Busy,
    output logic              Done,
    output logic [IDX_W:0]    IssuedCount
);

    localparam int            c_req_w = PROC_W + 2 + ADDR_W + DATA_W;
    localparam logic [IDX_W:0] c_depth = (IDX_W + 1)'(DEPTH);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W:0]       len_q, len_d;
    logic [IDX_W:0]       cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic [c_req_w-1:0]   req_q, req_d;

    logic                 w_we;
    logic                 w_start;
    logic                 w_last;
    logic                 w_loop;
    logic [IDX_W:0]       w_eff_len;
    logic [IDX_W:0]       w_cnt_inc;
    logic [IDX_W-1:0]     w_rd_idx;
    logic [c_req_w-1:0]   w_rd_data;

`ifdef MSI_STIM_LOOP_EN
    assign w_loop = Loop;
`else
    assign w_loop = Loop & 1'b0;
`endif

    // Program writes only land between runs and only for existing entries
    assign w_we      = ProgWe && (state_q != ST_RUN) && ({1'b0, ProgIdx} < c_depth);
    assign w_start   = Start && !ProgWe && (Length != '0);
    assign w_eff_len = (Length > c_depth) ? c_depth : Length;
    assign w_last    = ({1'b0, idx_q} == (len_q - 1'b1));
    assign w_cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Read address is the entry loaded on the coming edge: the next entry
    // mid-run, otherwise entry 0 (run start or loop wrap)
    assign w_rd_idx = ((state_q == ST_RUN) && !w_last) ? idx_q + 1'b1 : '0;

    msi_stim_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .WIDTH (c_req_w)
    ) u_mem (
        .clk     (Clock),
        .i_we    (w_we),
        .i_waddr (ProgIdx),
        .i_wdata ({ProgProc, ProgOp, ProgAddr, ProgData}),
        .i_raddr (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    // Next-state logic: start, handshake advance, wrap/finish and abort
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        done_d  = done_q;
        req_d   = req_q;
        case (state_q)
            ST_RUN: begin
                done_d = 1'b0;
                if (Abort) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else if (valid_q && ReqReady) begin
                    cnt_d = w_cnt_inc;
                    if (!w_last) begin
                        idx_d = idx_q + 1'b1;
                        req_d = w_rd_data;
                    end else if (w_loop) begin
                        idx_d  = '0;
                        req_d  = w_rd_data;
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end else if (w_start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    len_d   = w_eff_len;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    done_d  = 1'b0;
                    req_d   = w_rd_data;
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            req_q   <= req_d;
        end
    end

    assign ReqValid    = valid_q;
    assign Done        = done_q;
    assign IssuedCount = cnt_q;
    assign Busy        = (state_q == ST_RUN);
    assign {Processor, WriteOrRead, AddressTest, DataTest} = req_q;

endmodule
`default_nettype wire
